// File: rtl/router_pkg.sv
// Shared router types: receive-endpoint FSM encoding and packet counter width.
package router_pkg;
  typedef enum logic {RX_IDLE, RX_CAPTURE} rx_state_t;
  localparam int PKT_COUNT_W = 16;
endpackage

// File: rtl/rt_sync_fifo.sv
// Single-clock FIFO with count-based full/empty; push while full is accepted only alongside a pop.
module rt_sync_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale entries are unreachable once the count clears.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/rt_rx_endpoint.sv
// Toggle req/ack link receiver: synchronises req, captures packets into a FIFO,
// and presents them as a valid/ready stream with the destination header split off.
//
//   state      | meaning
//   RX_IDLE    | waiting for a new req phase with room in the FIFO
//   RX_CAPTURE | push in_data, record the phase, toggle ack, count the packet
module rt_rx_endpoint
  import router_pkg::*;
#(
  parameter int n           = 32,
  parameter int X_BITS      = 1,
  parameter int Y_BITS      = 1,
  parameter int packet_size = n + X_BITS + Y_BITS,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_req,
  output logic                   in_ack,
  input  logic [packet_size-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [X_BITS-1:0]      out_dstx,
  output logic [Y_BITS-1:0]      out_dsty,
  output logic [n-1:0]           out_payload,
  output logic [PKT_COUNT_W-1:0] pkt_count
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_sync, pending;
  rx_state_t              state_q;
  logic                   req_seen_q, ack_q;
  logic [PKT_COUNT_W-1:0] pkt_count_q;
  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [packet_size-1:0] head;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_req};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign req_sync = sync_q[SYNC_STAGES-1];
  assign pending  = (req_sync != req_seen_q);

  // Full is sampled in IDLE only; between then and CAPTURE only pops can happen.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      req_seen_q  <= 1'b0;
      ack_q       <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (pending && !fifo_full) state_q <= RX_CAPTURE;
        end
        RX_CAPTURE: begin
          req_seen_q  <= req_sync;
          ack_q       <= ~ack_q;
          pkt_count_q <= pkt_count_q + PKT_COUNT_W'(1);
          state_q     <= RX_IDLE;
        end
      endcase
    end
  end

  assign fifo_push = (state_q == RX_CAPTURE);
  assign fifo_pop  = out_valid && out_ready;

  rt_sync_fifo #(
    .WIDTH(packet_size),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata(in_data),
    .pop  (fifo_pop),
    .rdata(head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign in_ack      = ack_q;
  assign pkt_count   = pkt_count_q;
  assign out_valid   = !fifo_empty;
  assign out_dstx    = head[packet_size-1 -: X_BITS];
  assign out_dsty    = head[packet_size-1-X_BITS -: Y_BITS];
  assign out_payload = head[n-1:0];
endmodule

// File: tb/tb_rt_rx_endpoint.sv
// Directed bench for rt_rx_endpoint with default parameters.
module tb_rt_rx_endpoint;
  localparam int PS = 34;

  logic          clk = 1'b0;
  logic          rst, in_req, in_ack, out_valid, out_ready;
  logic [PS-1:0] in_data;
  logic [0:0]    out_dstx, out_dsty;
  logic [31:0]   out_payload;
  logic [15:0]   pkt_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rt_rx_endpoint dut (
    .clk        (clk),
    .rst        (rst),
    .in_req     (in_req),
    .in_ack     (in_ack),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_dstx   (out_dstx),
    .out_dsty   (out_dsty),
    .out_payload(out_payload),
    .pkt_count  (pkt_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input logic lvl, input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (in_ack === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic        exp_ack;
    bit          ok;
    int          toggles, beats;
    logic        prev;
    logic [31:0] got[$];

    rst = 1'b1; in_req = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_ack", in_ack, 0);
    check("rst_count", pkt_count, 0);

    // Single packet: ack after the 4th edge.
    in_data = {2'b01, 32'hFFFF_FFFF}; in_req = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();
    check("single_ack_e3", in_ack, 0);
    check("single_valid_e3", out_valid, 0);
    tick();
    check("single_ack_e4", in_ack, 1);
    check("single_valid_e4", out_valid, 1);
    check("single_dstx", out_dstx, 0);
    check("single_dsty", out_dsty, 1);
    check("single_payload", out_payload, 32'hFFFF_FFFF);
    check("single_count", pkt_count, 1);
    tick();
    check("single_popped", out_valid, 0);

    // Backpressure: four fit, the fifth ack is withheld.
    out_ready = 1'b0;
    exp_ack = 1'b1;
    for (int p = 1; p <= 4; p++) begin
      in_data = {2'b10, 32'(p)};
      in_req = ~in_req;
      exp_ack = ~exp_ack;
      wait_ack(exp_ack, 12, ok);
      check("bp_ack", ok, 1);
    end
    in_data = {2'b10, 32'd5};
    in_req = ~in_req;
    repeat (20) tick();
    check("bp5_withheld", in_ack, exp_ack);
    check("bp_head_valid", out_valid, 1);
    check("bp_head_payload", out_payload, 1);
    check("bp_head_dstx", out_dstx, 1);
    check("bp_head_dsty", out_dsty, 0);
    check("bp_count5", pkt_count, 5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_next_head", out_payload, 2);
    exp_ack = ~exp_ack;
    wait_ack(exp_ack, 12, ok);
    check("bp5_ack", ok, 1);
    check("bp_count6", pkt_count, 6);

    // Drain while the withheld sixth packet gets captured alongside pops.
    in_data = {2'b10, 32'd6};
    in_req = ~in_req;
    repeat (5) tick();
    check("pp_withheld", in_ack, exp_ack);
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) got.push_back(out_payload);
      tick();
    end
    out_ready = 1'b0;
    exp_ack = ~exp_ack;
    check("pp_ack", in_ack, exp_ack);
    check("pp_beats", got.size(), 5);
    for (int k = 0; k < got.size() && k < 5; k++)
      check("pp_order", got[k], 32'(k + 2));
    check("pp_empty", out_valid, 0);
    check("pp_count", pkt_count, 7);

    // Reset with 3 stored entries and the FSM in CAPTURE.
    for (int p = 7; p <= 9; p++) begin
      in_data = {2'b00, 32'(p)};
      in_req = ~in_req;
      exp_ack = ~exp_ack;
      wait_ack(exp_ack, 12, ok);
      check("mid_fill_ack", ok, 1);
    end
    in_data = {2'b00, 32'd10};
    in_req = ~in_req;
    tick(); tick(); tick();
    rst = 1'b1; in_req = 1'b0;
    tick();
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ack", in_ack, 0);
    check("mid_rst_count", pkt_count, 0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
    check("mid_rst_no_write", out_valid, 0);
    check("mid_rst_ack_idle", in_ack, 0);

    // Stability: one toggle held for 20 cycles yields exactly one ack and one beat.
    in_data = {2'b11, 32'hA5A5_5A5A};
    in_req = 1'b1;
    toggles = 0;
    prev = in_ack;
    repeat (20) begin
      tick();
      if (in_ack !== prev) toggles++;
      prev = in_ack;
    end
    check("stab_toggles", toggles, 1);
    check("stab_valid", out_valid, 1);
    check("stab_payload", out_payload, 32'hA5A5_5A5A);
    check("stab_dstx", out_dstx, 1);
    check("stab_dsty", out_dsty, 1);
    check("stab_count", pkt_count, 1);
    out_ready = 1'b1;
    beats = 0;
    repeat (10) begin
      if (out_valid) beats++;
      tick();
    end
    out_ready = 1'b0;
    check("stab_beats", beats, 1);

    // Counter wrap.
    force dut.pkt_count_q = 16'hFFFF;
    tick();
    release dut.pkt_count_q;
    tick();
    check("wrap_preload", pkt_count, 16'hFFFF);
    in_data = {2'b00, 32'h0000_1234};
    in_req = 1'b0;
    wait_ack(1'b0, 12, ok);
    check("wrap_ack", ok, 1);
    check("wrap_count", pkt_count, 0);
    check("wrap_payload", out_payload, 32'h0000_1234);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
